// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and select constants for the slave mux
//
// Purpose : HTRANS/HRESP encodings, port count, one-hot data-phase select
//           layout and the default-slave FSM state type.
// Ports   : none (package).
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Mapped slave ports; the default slave takes the slot after the last one.
  localparam int NPORT = 5;
  localparam int NSEL  = NPORT + 1;

  localparam int SEL_P0  = 0;
  localparam int SEL_P1  = 1;
  localparam int SEL_P2  = 2;
  localparam int SEL_P3  = 3;
  localparam int SEL_P4  = 4;
  localparam int SEL_DEF = 5;

  typedef logic [NSEL-1:0] sel_t;

  localparam sel_t SEL_DEF_OH = sel_t'(1) << SEL_DEF;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } dslv_state_t;

  // True for NONSEQ and SEQ, the transfer types that demand a response.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// rtl/ahblite_default_slave.sv - default slave giving two-cycle ERROR to unmapped active transfers
//
// Purpose : answers every address phase that no mapped slave claims.
//           Active transfers get the AHB two-cycle ERROR (ready low, then
//           ready high, both with resp=ERROR); IDLE/BUSY get zero-wait OKAY.
// Ports   : HCLK      in   clock
//           HRESET    in   synchronous active-high reset
//           HSEL_def  in   default slave owns the current address phase
//           HTRANS    in   master transfer type
//           HREADY    in   shared bus ready (the mux output)
//           HREADYOUT out  default slave ready
//           HRESP     out  default slave response
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL_def,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  dslv_state_t state, state_nxt;
  logic        take_err;

  // An address phase is only accepted when the bus is ready; ERR2 drives
  // ready high so a back-to-back unmapped transfer is accepted there too.
  assign take_err = HREADY & HSEL_def & htrans_active(HTRANS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= D_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = D_IDLE;
    case (state)
      D_IDLE:  state_nxt = take_err ? D_ERR1 : D_IDLE;
      D_ERR1:  state_nxt = D_ERR2;
      D_ERR2:  state_nxt = take_err ? D_ERR1 : D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      D_IDLE: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
      end
      D_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      D_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// rtl/ahblite_slave_mux.sv - AHB-Lite data-phase slave multiplexer with built-in default slave
//
// Purpose : qualifies the decoder selects in the address phase, registers
//           the data-phase owner, and returns that owner's ready/response/
//           read data to the master. Unclaimed address phases go to the
//           internal default slave.
// Ports   : HCLK                 in   clock
//           HRESET               in   synchronous active-high reset
//           HTRANS[1:0]          in   master transfer type
//           P0..P4_HSEL          in   decoder selects (address phase)
//           P0..P4_HREADYOUT     in   slave ready
//           P0..P4_HRESP         in   slave response
//           P0..P4_HRDATA[31:0]  in   slave read data
//           HREADY               out  muxed ready to master and all slaves
//           HRESP                out  muxed response
//           HRDATA[31:0]         out  muxed read data
module ahblite_slave_mux
  import ahb_pkg::*;
#(
  parameter int Port0_en = 1,
  parameter int Port1_en = 1,
  parameter int Port2_en = 1,
  parameter int Port3_en = 1,
  parameter int Port4_en = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [NPORT-1:0] port_en;
  logic [NPORT-1:0] hsel_raw;
  logic [NPORT-1:0] hsel_eff;
  logic [NPORT-1:0] ready_in;
  logic [NPORT-1:0] resp_in;
  logic [31:0]      rdata_in [NPORT];

  sel_t owner;
  sel_t sel_q;
  logic def_ready;
  logic def_resp;

  assign port_en  = {Port4_en != 0, Port3_en != 0, Port2_en != 0,
                     Port1_en != 0, Port0_en != 0};
  assign hsel_raw = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
  assign ready_in = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT,
                     P1_HREADYOUT, P0_HREADYOUT};
  assign resp_in  = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

  assign rdata_in[0] = P0_HRDATA;
  assign rdata_in[1] = P1_HRDATA;
  assign rdata_in[2] = P2_HRDATA;
  assign rdata_in[3] = P3_HRDATA;
  assign rdata_in[4] = P4_HRDATA;

  // A select on an absent port is ignored so it falls through to the
  // default slave rather than into a port nobody answers.
  assign hsel_eff = hsel_raw & port_en;

  // Address-phase owner. Scanning high to low lets the lowest asserted
  // index overwrite the others, keeping multi-hot decoder faults
  // deterministic.
  always_comb begin
    owner = SEL_DEF_OH;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (hsel_eff[k]) begin
        owner = sel_t'(1) << k;
      end
    end
  end

  // Data-phase owner advances only on a completed bus cycle; a stalling
  // slave therefore holds the mux on itself for as long as it likes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= SEL_DEF_OH;
    end else if (HREADY) begin
      sel_q <= owner;
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL_def  (owner[SEL_DEF]),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (def_ready),
    .HRESP     (def_resp)
  );

  // Return path is purely combinational from the registered owner, so a
  // mapped slave sees no added latency.
  always_comb begin
    HREADY = def_ready;
    HRESP  = def_resp;
    HRDATA = 32'h0;
    for (int k = 0; k < NPORT; k++) begin
      if (sel_q[k]) begin
        HREADY = ready_in[k];
        HRESP  = resp_in[k];
        HRDATA = rdata_in[k];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb/tb_ahblite_slave_mux.sv - self-checking bench for ahblite_slave_mux
module tb_ahblite_slave_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic [4:0]  hsel;
  logic [4:0]  rdyo;
  logic [4:0]  resp;
  logic [31:0] rdata [5];
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the data phase (0..4 mapped, 5 = unmapped),
  // and which cycle of an unmapped ERROR response is in progress (0 none).
  bit en [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int m_owner = 5;
  int m_err   = 0;
  bit m_valid = 1'b0;

  always #5 HCLK = ~HCLK;

  ahblite_slave_mux #(
    .Port0_en(1), .Port1_en(1), .Port2_en(1), .Port3_en(1), .Port4_en(0)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HTRANS       (HTRANS),
    .P0_HSEL      (hsel[0]),
    .P1_HSEL      (hsel[1]),
    .P2_HSEL      (hsel[2]),
    .P3_HSEL      (hsel[3]),
    .P4_HSEL      (hsel[4]),
    .P0_HREADYOUT (rdyo[0]),
    .P1_HREADYOUT (rdyo[1]),
    .P2_HREADYOUT (rdyo[2]),
    .P3_HREADYOUT (rdyo[3]),
    .P4_HREADYOUT (rdyo[4]),
    .P0_HRESP     (resp[0]),
    .P1_HRESP     (resp[1]),
    .P2_HRESP     (resp[2]),
    .P3_HRESP     (resp[3]),
    .P4_HRESP     (resp[4]),
    .P0_HRDATA    (rdata[0]),
    .P1_HRDATA    (rdata[1]),
    .P2_HRDATA    (rdata[2]),
    .P3_HRDATA    (rdata[3]),
    .P4_HRDATA    (rdata[4]),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int addr_owner();
    for (int k = 0; k < 5; k++) begin
      if (hsel[k] && en[k]) return k;
    end
    return 5;
  endfunction

  // One bus cycle: compare outputs against the model mid-cycle, then
  // advance the model with the inputs seen at the rising edge.
  task automatic tick(input string tag);
    logic        er, ep;
    logic [31:0] ed;
    int          nxt_owner, nxt_err;
    @(negedge HCLK);
    if (m_owner < 5) begin
      er = rdyo[m_owner];
      ep = resp[m_owner];
      ed = rdata[m_owner];
    end else begin
      er = (m_err != 1);
      ep = (m_err != 0);
      ed = 32'h0;
    end
    if (m_valid) begin
      check({tag, ".hready"}, {31'h0, HREADY}, {31'h0, er});
      check({tag, ".hresp"},  {31'h0, HRESP},  {31'h0, ep});
      check({tag, ".hrdata"}, HRDATA, ed);
    end
    @(posedge HCLK);
    if (HRESET) begin
      m_owner = 5;
      m_err   = 0;
      m_valid = 1'b1;
    end else begin
      nxt_owner = addr_owner();
      if (m_err == 1) nxt_err = 2;
      else if (er && nxt_owner == 5 && HTRANS[1]) nxt_err = 1;
      else nxt_err = 0;
      if (er) m_owner = nxt_owner;
      m_err = nxt_err;
    end
    #1;
  endtask

  task automatic bus_idle();
    HTRANS = 2'b00;
    hsel   = 5'b0;
    rdyo   = 5'b11111;
    resp   = 5'b0;
    for (int k = 0; k < 5; k++) rdata[k] = $urandom;
  endtask

  task automatic expect_now(input string tag, input logic r, input logic e);
    #1;
    check({tag, ".hready"}, {31'h0, HREADY}, {31'h0, r});
    check({tag, ".hresp"},  {31'h0, HRESP},  {31'h0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random slave inputs.
    HRESET = 1'b1;
    HTRANS = 2'($urandom);
    hsel   = 5'($urandom);
    rdyo   = 5'($urandom);
    resp   = 5'($urandom);
    for (int k = 0; k < 5; k++) rdata[k] = $urandom;
    tick("rst0");
    tick("rst1");
    #1;
    check("rst.hready", {31'h0, HREADY}, 32'h1);
    check("rst.hresp",  {31'h0, HRESP},  32'h0);
    check("rst.hrdata", HRDATA, 32'h0);
    check("rst.noX", {31'h0, $isunknown({HREADY, HRESP, HRDATA})}, 32'h0);
    HRESET = 1'b0;
    bus_idle();
    tick("idle");

    // Mapped read on P1 with two wait states; P0 data must not leak.
    HTRANS = 2'b10; hsel = 5'b00010;
    tick("rd.addr");
    bus_idle();
    rdata[1] = 32'hDEADBEEF; rdyo[1] = 1'b0;
    expect_now("rd.w0", 1'b0, 1'b0);
    tick("rd.w0");
    rdata[0] = 32'h0BADF00D;
    expect_now("rd.w1", 1'b0, 1'b0);
    tick("rd.w1");
    rdyo[1] = 1'b1;
    #1;
    check("rd.data", HRDATA, 32'hDEADBEEF);
    check("rd.done", {31'h0, HREADY}, 32'h1);
    tick("rd.done");

    // Pipelined switch P0 -> P3 with no inserted wait.
    bus_idle();
    HTRANS = 2'b10; hsel = 5'b00001;
    tick("pl.a0");
    HTRANS = 2'b10; hsel = 5'b01000;
    rdata[0] = 32'h11111111; rdata[3] = 32'h33333333;
    #1;
    check("pl.d0", HRDATA, 32'h11111111);
    check("pl.d0rdy", {31'h0, HREADY}, 32'h1);
    tick("pl.a1");
    HTRANS = 2'b00; hsel = 5'b0;
    #1;
    check("pl.d1", HRDATA, 32'h33333333);
    check("pl.d1rdy", {31'h0, HREADY}, 32'h1);
    tick("pl.d1");

    // Unmapped NONSEQ: two-cycle ERROR then OKAY.
    bus_idle();
    HTRANS = 2'b10;
    tick("um.addr");
    HTRANS = 2'b00;
    expect_now("um.err1", 1'b0, 1'b1);
    tick("um.err1");
    expect_now("um.err2", 1'b1, 1'b1);
    tick("um.err2");
    expect_now("um.ok", 1'b1, 1'b0);
    tick("um.ok");
    // Unmapped IDLE: zero-wait OKAY.
    HTRANS = 2'b00;
    tick("ui.addr");
    expect_now("ui.ok", 1'b1, 1'b0);
    tick("ui.ok");

    // Disabled P4 goes to the default slave; second unmapped transfer held
    // on the bus is sampled in ERR2 and yields a second ERROR pair.
    bus_idle();
    HTRANS = 2'b10; hsel = 5'b10000;
    tick("dp.addr");
    hsel = 5'b0;
    expect_now("dp.err1", 1'b0, 1'b1);
    tick("dp.err1");
    expect_now("dp.err2", 1'b1, 1'b1);
    tick("dp.err2");
    HTRANS = 2'b00;
    expect_now("bb.err1", 1'b0, 1'b1);
    tick("bb.err1");
    expect_now("bb.err2", 1'b1, 1'b1);
    tick("bb.err2");
    expect_now("bb.ok", 1'b1, 1'b0);
    tick("bb.ok");

    // Reset during a P2 wait state.
    HTRANS = 2'b10; hsel = 5'b00100;
    tick("mr.addr");
    bus_idle();
    rdyo[2] = 1'b0;
    tick("mr.wait");
    HRESET = 1'b1;
    tick("mr.rst");
    HRESET = 1'b0;
    #1;
    check("mr.hready", {31'h0, HREADY}, 32'h1);
    check("mr.hresp",  {31'h0, HRESP},  32'h0);
    check("mr.hrdata", HRDATA, 32'h0);
    tick("mr.after");

    // Randomized traffic, including multi-hot selects and sporadic reset.
    for (int i = 0; i < 3000; i++) begin
      HRESET = ($urandom_range(0, 63) == 0);
      HTRANS = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       hsel = 5'b0;
        1:       hsel = 5'($urandom);
        default: hsel = 5'b1 << $urandom_range(0, 4);
      endcase
      for (int k = 0; k < 5; k++) begin
        rdyo[k]  = ($urandom_range(0, 3) != 0);
        resp[k]  = ($urandom_range(0, 7) == 0);
        rdata[k] = $urandom;
      end
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Downstream partner of the AHB-Lite address decoder.
- Consumes the five decoder HSEL outputs in the address phase and registers which slave owns the following data phase.
- In the data phase, multiplexes that slave's HREADYOUT/HRESP/HRDATA back to the Cortex-M0 master; drives the shared HREADY to master and all slaves.
- Contains a built-in default slave that gives the AHB two-cycle ERROR response to any active transfer hitting unmapped space.

Parameters:
- Port0_en, 1, RAMCODE port present; 0 forces its HSEL to be ignored.
- Port1_en, 1, RAMDATA port present.
- Port2_en, 1, peripheral (0x4001xxxx) port present.
- Port3_en, 1, UART port present.
- Port4_en, 0, spare port present.

Ports:
- HCLK  in  1  system clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HTRANS  in  2  master transfer type; bit1=1 means NONSEQ/SEQ (active).
- P0_HSEL..P4_HSEL  in  1 each  decoder selects, address phase.
- P0_HREADYOUT..P4_HREADYOUT  in  1 each  slave ready.
- P0_HRESP..P4_HRESP  in  1 each  slave response (0 OKAY, 1 ERROR).
- P0_HRDATA..P4_HRDATA  in  32 each  slave read data.
- HREADY  out  1  muxed ready to master and all slaves.
- HRESP  out  1  muxed response to master.
- HRDATA  out  32  muxed read data to master.

Behaviour:
- Select qualification: effective sel_k = Pk_HSEL & Portk_en. If no effective sel_k is high, the address phase belongs to the default slave. If several are high, the lowest index wins. This is a decoder fault, but the mux must stay deterministic.
- Data-phase select register sel_q: 6-way one-hot (P0..P4, DEF). Loads the address-phase owner on any rising edge where HREADY (own output) = 1. Holds while HREADY = 0.
- Output mux, combinational from sel_q:
  - sel_q = Pk: HREADY = Pk_HREADYOUT, HRESP = Pk_HRESP, HRDATA = Pk_HRDATA.
  - sel_q = DEF: HREADY/HRESP come from the default-slave FSM; HRDATA = 32'h0.
- Default-slave FSM states: D_IDLE, D_ERR1, D_ERR2.
  - D_IDLE: drives ready=1, resp=0. Moves to D_ERR1 when HREADY=1, the default slave owns the address phase, and HTRANS[1]=1. Otherwise stays (IDLE/BUSY to unmapped space gets zero-wait OKAY).
  - D_ERR1: drives ready=0, resp=1. Always moves to D_ERR2.
  - D_ERR2: drives ready=1, resp=1. Same transition rule as D_IDLE: back-to-back active unmapped transfer goes to D_ERR1, else D_IDLE.
- Transfer sampled in D_ERR2: the sample is honoured (sel_q reloads normally). The bus does not rely on the master inserting IDLE.
- Latency: mapped slave, 0 cycles added (pure combinational return path plus registered select). Unmapped active transfer, exactly 2 data-phase cycles.
- Reset (synchronous; also applies mid-transfer): next edge forces sel_q = DEF and FSM = D_IDLE. Outputs after that edge: HREADY=1, HRESP=0, HRDATA=0. Any in-flight data phase is abandoned.
- A slave stalling with HREADYOUT=0 freezes sel_q indefinitely. There is no timeout.
- A slave's two-cycle ERROR is passed through unmodified.

Decomposition:
- Shared package (ahb_pkg): HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP_OKAY/HRESP_ERROR, port count constant NPORT=5, one-hot select index constants.
- One sub-module: ahblite_default_slave, holding the 3-state FSM. Inputs: HCLK, HRESET, HSEL_def, HTRANS, HREADY. Outputs: HREADYOUT, HRESP.
- The mux and select register stay in the top.

Test Plan:
- Reset: assert HRESET for 2 cycles with random slave inputs -> HREADY=1, HRESP=0, HRDATA=0, no X.
- Mapped read: NONSEQ with P1_HSEL=1, then P1_HRDATA=32'hDEADBEEF and P1_HREADYOUT low for 2 cycles -> HREADY low 2 cycles then high, HRDATA=32'hDEADBEEF. P0 data change during that window does not reach HRDATA.
- Pipelined switch: back-to-back NONSEQ to P0 then P3 (P0 data=32'h11111111, P3 data=32'h33333333) -> consecutive data phases return 11111111 then 33333333 with no extra wait.
- Unmapped: NONSEQ with all HSEL=0 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then OKAY. Same stimulus with HTRANS=IDLE -> HREADY=1, HRESP=0 immediately.
- Disabled port: Port4_en=0, P4_HSEL=1, NONSEQ -> default-slave two-cycle ERROR. Also a back-to-back unmapped NONSEQ sampled in D_ERR2 -> second ERROR pair directly follows.
- Reset mid-operation: HRESET during a P2 wait state (P2_HREADYOUT=0) -> next edge HREADY=1, HRESP=0, HRDATA=0.
